dds_core: RTL

DDS_CORE -- requirements
Module: dds_core

---
 rtl/dds_core.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dds_core.sv
// dds_core -- direct digital synthesis sample generator.
//
// Walks a 32-bit phase accumulator, addresses an external one-cycle-latency
// sine LUT with the top LUT_AW phase bits, scales the returned word by an
// unsigned Q0.16 gain and presents one sample per divided sample period.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_dds_ctrl        bit0 EN (level, rising edge starts), bit1 BURST
//   i_dds_thetas      start phase (latched at start)
//   i_dds_deltas      phase increment per sample (live)
//   i_dds_ampls       bits[15:0] unsigned gain Q0.16 (live)
//   i_dds_clk_div     sample period = clk_div+1 clocks (live)
//   i_dds_lngth       samples per burst (latched at start)
//   o_dds_lut_addr    registered LUT address
//   i_dds_lut_data    LUT word, valid one cycle after the address
//   o_dds_signal      current scaled sample
//   o_dds_valid       one-cycle pulse when o_dds_signal updates
//   o_dds_busy        running or samples still in flight
//   o_dds_done        burst complete, waiting for EN to drop
module dds_core #(
  parameter int SIG_WIDTH = 16,
  parameter int LUT_AW    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_dds_ctrl,
  input  logic [31:0]          i_dds_thetas,
  input  logic [31:0]          i_dds_deltas,
  input  logic [31:0]          i_dds_ampls,
  input  logic [31:0]          i_dds_clk_div,
  input  logic [31:0]          i_dds_lngth,
  output logic [LUT_AW-1:0]    o_dds_lut_addr,
  input  logic [SIG_WIDTH-1:0] i_dds_lut_data,
  output logic [SIG_WIDTH-1:0] o_dds_signal,
  output logic                 o_dds_valid,
  output logic                 o_dds_busy,
  output logic                 o_dds_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // tick -> addr reg -> LUT data -> signal reg; vld_pipe[STAGES] is o_dds_valid
  localparam int STAGES = 2;
  localparam int PW     = SIG_WIDTH + 17;

  logic [1:0]        state;
  logic              en_q;
  logic [31:0]       acc, div_cnt, smp_cnt, lngth_q;
  logic [STAGES:0]   vld_pipe;

  logic              en, burst, start, abort, flush, tick;
  logic [PW-1:0]     lut_x, gain_x, prod;

  assign en    = i_dds_ctrl[0];
  assign burst = i_dds_ctrl[1];
  assign start = (state == S_IDLE) && en && !en_q;
  assign abort = (state == S_RUN) && !en;
  // aborts and restarts both throw away whatever is still in flight
  assign flush = abort || start;
  assign tick  = (state == S_RUN) && en && (div_cnt >= i_dds_clk_div);

  // signed LUT word times zero-extended gain; 33 bits holds the full range,
  // so bits [31:16] never overflow even at gain 0xFFFF
  assign lut_x  = {{17{i_dds_lut_data[SIG_WIDTH-1]}}, i_dds_lut_data};
  assign gain_x = {{(SIG_WIDTH+1){1'b0}}, i_dds_ampls[15:0]};
  assign prod   = lut_x * gain_x;

  logic unused_bits;
  assign unused_bits = ^{i_dds_ctrl[31:2], i_dds_ampls[31:16],
                         prod[PW-1:SIG_WIDTH+16], prod[15:0]};

  assign o_dds_valid = vld_pipe[STAGES];
  assign o_dds_busy  = (state == S_RUN) || (|vld_pipe[STAGES-1:0]);
  assign o_dds_done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      en_q           <= 1'b0;
      acc            <= '0;
      div_cnt        <= '0;
      smp_cnt        <= '0;
      lngth_q        <= '0;
      vld_pipe       <= '0;
      o_dds_lut_addr <= '0;
      o_dds_signal   <= '0;
    end else begin
      en_q     <= en;
      vld_pipe <= flush ? '0 : {vld_pipe[STAGES-1:0], tick};
      if (vld_pipe[STAGES-1] && !flush)
        o_dds_signal <= prod[SIG_WIDTH+15:16];

      case (state)
        S_IDLE: if (start) begin
          acc     <= i_dds_thetas;
          div_cnt <= '0;
          smp_cnt <= '0;
          lngth_q <= i_dds_lngth;
          state   <= (burst && i_dds_lngth == 32'd0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (tick) begin
            o_dds_lut_addr <= acc[31 -: LUT_AW];
            acc            <= acc + i_dds_deltas;
            smp_cnt        <= smp_cnt + 32'd1;
            div_cnt        <= '0;
            if (burst && (smp_cnt + 32'd1 == lngth_q))
              state <= S_DONE;
          end else begin
            div_cnt <= div_cnt + 32'd1;
          end
        end
        S_DONE: if (!en) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
